// File: rtl/sync_filter_pkg.sv
// Shared types and default constants for the synchronized edge filter.
package sync_filter_pkg;

    localparam int DEFAULT_FILTER_CYCLES = 4;
    localparam int DEFAULT_CNT_WIDTH     = 16;

    // Debounce FSM states: two stable levels and two qualification states.
    typedef enum logic [1:0] {
        LOW        = 2'd0,
        CHECK_HIGH = 2'd1,
        HIGH       = 2'd2,
        CHECK_LOW  = 2'd3
    } filter_state_t;

endpackage

// File: rtl/sync_edge_filter_sat_counter.sv
// Saturating event counter with synchronous clear and a sticky saturation flag.
// A clear that coincides with an increment keeps the event, so the count restarts at 1.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count,
    output logic             sat
);

    localparam logic [WIDTH-1:0] COUNT_MAX = '1;

    logic [WIDTH-1:0] count_next;

    // Next count: clear wins over holding, but never drops a coincident increment.
    always_comb begin
        count_next = count;
        if (clr) begin
            count_next = inc ? WIDTH'(1) : '0;
        end else if (inc && (count != COUNT_MAX)) begin
            count_next = count + WIDTH'(1);
        end
    end

    // Count register and sticky flag, which rises on the same edge the count reaches all-ones.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
            sat   <= 1'b0;
        end else begin
            count <= count_next;
            sat   <= clr ? 1'b0 : (sat | (count_next == COUNT_MAX));
        end
    end

endmodule

// File: rtl/sync_edge_filter.sv
// Debounce filter for an already-synchronized level.
// A level change is accepted only after FILTER_CYCLES consecutive differing samples.
// Accepted changes produce registered rise/fall strobes, and accepted rises are counted.
module sync_edge_filter
    import sync_filter_pkg::*;
#(
    parameter int FILTER_CYCLES = DEFAULT_FILTER_CYCLES,
    parameter int CNT_WIDTH     = DEFAULT_CNT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 signal_in,
    input  logic                 clear_count,
    output logic                 level_out,
    output logic                 rise_pulse,
    output logic                 fall_pulse,
    output logic [CNT_WIDTH-1:0] edge_count,
    output logic                 count_sat
);

    localparam int STAB_W = $clog2(FILTER_CYCLES + 1);
    // Value the stability counter holds when the current sample completes qualification.
    localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(FILTER_CYCLES - 1);
    localparam logic [STAB_W-1:0] STAB_ONE  = STAB_W'(1);
    // With a single-sample filter the qualification states are skipped entirely.
    localparam bit SINGLE_SAMPLE = (FILTER_CYCLES == 1);

    filter_state_t     state, state_next;
    logic [STAB_W-1:0] stab_cnt, stab_next;
    logic              level_next, rise_next, fall_next;

    // FSM state and stability counter registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= LOW;
            stab_cnt <= '0;
        end else begin
            state    <= state_next;
            stab_cnt <= stab_next;
        end
    end

    // Next-state logic: the first differing sample counts as one, a matching sample abandons.
    always_comb begin
        state_next = state;
        stab_next  = stab_cnt;
        case (state)
            LOW: begin
                if (signal_in) begin
                    if (SINGLE_SAMPLE) begin
                        state_next = HIGH;
                        stab_next  = '0;
                    end else begin
                        state_next = CHECK_HIGH;
                        stab_next  = STAB_ONE;
                    end
                end
            end
            CHECK_HIGH: begin
                if (!signal_in) begin
                    state_next = LOW;
                    stab_next  = '0;
                end else if (stab_cnt == STAB_LAST) begin
                    state_next = HIGH;
                    stab_next  = '0;
                end else begin
                    stab_next = stab_cnt + STAB_ONE;
                end
            end
            HIGH: begin
                if (!signal_in) begin
                    if (SINGLE_SAMPLE) begin
                        state_next = LOW;
                        stab_next  = '0;
                    end else begin
                        state_next = CHECK_LOW;
                        stab_next  = STAB_ONE;
                    end
                end
            end
            CHECK_LOW: begin
                if (signal_in) begin
                    state_next = HIGH;
                    stab_next  = '0;
                end else if (stab_cnt == STAB_LAST) begin
                    state_next = LOW;
                    stab_next  = '0;
                end else begin
                    stab_next = stab_cnt + STAB_ONE;
                end
            end
            default: begin
                state_next = LOW;
                stab_next  = '0;
            end
        endcase
    end

    // Output decode: strobes only on accepted transitions, never on an abandoned check.
    always_comb begin
        level_next = level_out;
        rise_next  = 1'b0;
        fall_next  = 1'b0;
        if ((state_next == HIGH) && ((state == CHECK_HIGH) || (state == LOW))) begin
            level_next = 1'b1;
            rise_next  = 1'b1;
        end else if ((state_next == LOW) && ((state == CHECK_LOW) || (state == HIGH))) begin
            level_next = 1'b0;
            fall_next  = 1'b1;
        end
    end

    // Registered filtered level and edge strobes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            level_out  <= 1'b0;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
        end else begin
            level_out  <= level_next;
            rise_pulse <= rise_next;
            fall_pulse <= fall_next;
        end
    end

    sat_counter #(
        .WIDTH(CNT_WIDTH)
    ) u_rise_count (
        .clk  (clk),
        .rst_n(rst_n),
        .inc  (rise_pulse),
        .clr  (clear_count),
        .count(edge_count),
        .sat  (count_sat)
    );

endmodule
